// File: rtl/pb_conditioner.sv
// Multi-channel push-button conditioner: 2-flop sync, per-channel debounce FSM, press/release pulses, toggle.
// Optional auto-repeat of pb_press while a button is held, enabled by defining PB_AUTOREPEAT_EN.
module pb_conditioner #(
    parameter int unsigned         NUM_PB          = 4,
    parameter int unsigned         DEBOUNCE_CYCLES = 1000000,
    parameter logic [NUM_PB-1:0]   TOGGLE_INIT     = '1,
    parameter int unsigned         HOLD_CYCLES     = 50000000,
    parameter int unsigned         REPEAT_CYCLES   = 10000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_PB-1:0] pb_raw,
    output logic [NUM_PB-1:0] pb_level,
    output logic [NUM_PB-1:0] pb_press,
    output logic [NUM_PB-1:0] pb_release,
    output logic [NUM_PB-1:0] pb_toggle
);

    localparam int unsigned MAX_DH  = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
    localparam int          CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    logic [NUM_PB-1:0] sync1_q, sync2_q;
    logic [NUM_PB-1:0] press_q, release_q, toggle_q;
    logic [NUM_PB-1:0] press_d, release_d, toggle_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            toggle_q  <= TOGGLE_INIT;
        end else begin
            sync1_q   <= pb_raw;
            sync2_q   <= sync1_q;
            press_q   <= press_d;
            release_q <= release_d;
            toggle_q  <= toggle_d;
        end
    end

    for (genvar g = 0; g < NUM_PB; g++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             acc_press, acc_rel, rpt_fire;

        always_ff @(posedge clk) begin
            if (!rst) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            acc_press = 1'b0;
            acc_rel   = 1'b0;
            case (state_q)
                IDLE: begin
                    if (sync2_q[g]) begin
                        state_d = PRESS_WAIT;
                        cnt_d   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync2_q[g]) begin
                        state_d = IDLE;
                    end else if (cnt_q == DB_LAST) begin
                        state_d   = PRESSED;
                        acc_press = 1'b1;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                PRESSED: begin
                    if (!sync2_q[g]) begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync2_q[g]) begin
                        state_d = PRESSED;
                    end else if (cnt_q == DB_LAST) begin
                        state_d = IDLE;
                        acc_rel = 1'b1;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

`ifdef PB_AUTOREPEAT_EN
        localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
        localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

        logic [CNT_W-1:0] hold_q, hold_d;
        logic             rep_q, rep_d;

        always_ff @(posedge clk) begin
            if (!rst) begin
                hold_q <= '0;
                rep_q  <= 1'b0;
            end else begin
                hold_q <= hold_d;
                rep_q  <= rep_d;
            end
        end

        // Any (re)entry into PRESSED restarts the initial hold delay; RELEASE_WAIT just freezes it.
        always_comb begin
            hold_d   = hold_q;
            rep_d    = rep_q;
            rpt_fire = 1'b0;
            if (state_q != PRESSED && state_d == PRESSED) begin
                hold_d = '0;
                rep_d  = 1'b0;
            end else if (state_q == PRESSED && state_d == PRESSED) begin
                if (hold_q == (rep_q ? REP_LAST : HOLD_LAST)) begin
                    rpt_fire = 1'b1;
                    hold_d   = '0;
                    rep_d    = 1'b1;
                end else begin
                    hold_d = sat_inc(hold_q);
                end
            end
        end
`else
        assign rpt_fire = 1'b0;
`endif

        assign press_d[g]   = acc_press | rpt_fire;
        assign release_d[g] = acc_rel;
        assign toggle_d[g]  = toggle_q[g] ^ press_d[g];
        assign pb_level[g]  = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
    end

    assign pb_press   = press_q;
    assign pb_release = release_q;
    assign pb_toggle  = toggle_q;

endmodule
